// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings, BCD limits, blank masks and BCD increment helper
//   MODE_RUN/MODE_SET_HR/MODE_SET_MIN : mode output encodings
//   HR_MAX/MIN_MAX/SEC_MAX            : last value of each field before it wraps to 00
//   BLANK_HR/BLANK_MIN                : digit masks for the field being edited
package clock_pkg;
   typedef enum logic [1:0] {
      MODE_RUN     = 2'b00,
      MODE_SET_HR  = 2'b01,
      MODE_SET_MIN = 2'b10
   } mode_e;
   localparam int HR_MAX = 23;
   localparam int MIN_MAX = 59;
   localparam int SEC_MAX = 59;
   localparam logic [3:0] BLANK_HR = 4'b1100;
   localparam logic [3:0] BLANK_MIN = 4'b0011;
   // Next two-digit BCD value; returns 00 after max, so a result of 00 marks the wrap.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int max);
      if (int'(v[7:4]) * 10 + int'(v[3:0]) == max) return 8'h00;
      return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction
endpackage

// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: pushbutton inputs and display outputs of the clock controller
//   slave  (controller) : btn_mode, btn_inc in; in1..in4, blank, mode, colon out
//   master (board)      : the reverse direction
interface clock_mode_ctrl_if;
   logic       btn_mode, btn_inc;
   logic [3:0] in1, in2, in3, in4, blank;
   logic [1:0] mode;
   logic       colon;
   modport master(output btn_mode, btn_inc, input in1, in2, in3, in4, blank, mode, colon);
   modport slave(input btn_mode, btn_inc, output in1, in2, in3, in4, blank, mode, colon);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw pushbutton, debounces it and pulses once per accepted press
//   clk, clr : clock and asynchronous active-high reset
//   raw      : asynchronous active-high button
//   press    : one-cycle pulse on the accepted 0->1 level change
module btn_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic clr,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d, press_q, press_d, flip;
   // flip on the DEB_CYCLES-th consecutive sample that differs from the accepted level
   assign flip = sync_q[1] != level_q && cnt_q == CW'(DEB_CYCLES - 1);
   always_comb begin
      cnt_d = sync_q[1] == level_q || flip ? '0 : cnt_q + 1'b1;
      level_d = level_q ^ flip;
      press_d = flip && sync_q[1];
   end
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_q <= 2'b00;
         cnt_q <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         cnt_q <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end
   assign press = press_q;
endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: 24-hour BCD time keeping with a two-button set mode and blink mask
//   clk, clr         : system clock and asynchronous active-high reset
//   bus.btn_mode/inc : raw pushbuttons
//   bus.in1..in4     : HH:MM BCD digits, bus.blank: per-digit dark mask
//   bus.mode         : RUN/SET_HR/SET_MIN, bus.colon: seconds blink / steady in set
module clock_mode_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input logic clk,
   input logic clr,
   clock_mode_ctrl_if.slave bus
);
   localparam int PW = $clog2(CLK_HZ);
   localparam int QTR = CLK_HZ / 4;
   localparam int BW = $clog2(QTR + 1);
   mode_e         mode_q, mode_d;
   logic [7:0]    hr_q, hr_d, mn_q, mn_d, sc_q, sc_d, hr_n, mn_n, sc_n;
   logic [PW-1:0] pre_q, pre_d;
   logic [BW-1:0] bc_q, bc_d;
   logic [3:0]    blank_q, blank_d;
   logic          ph_q, ph_d, colon_q, colon_d;
   logic          mode_p, inc_p, inc_ok, tick, last;
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (.clk(clk), .clr(clr), .raw(bus.btn_mode), .press(mode_p));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (.clk(clk), .clr(clr), .raw(bus.btn_inc), .press(inc_p));
   assign hr_n = bcd_inc(hr_q, HR_MAX);
   assign mn_n = bcd_inc(mn_q, MIN_MAX);
   assign sc_n = bcd_inc(sc_q, SEC_MAX);
   assign tick = mode_q == MODE_RUN && pre_q == PW'(CLK_HZ - 1);
   assign last = bc_q == BW'(QTR - 1);
   // a mode press in the same cycle wins over inc
   assign inc_ok = inc_p && !mode_p && mode_q != MODE_RUN;
   always_comb begin
      mode_d = !mode_p ? mode_q : mode_q == MODE_RUN ? MODE_SET_HR : mode_q == MODE_SET_HR ? MODE_SET_MIN : MODE_RUN;
      hr_d = (inc_ok && mode_q == MODE_SET_HR) || (tick && sc_n == 8'h00 && mn_n == 8'h00) ? hr_n : hr_q;
      mn_d = (inc_ok && mode_q == MODE_SET_MIN) || (tick && sc_n == 8'h00) ? mn_n : mn_q;
      sc_d = mode_p || mode_q != MODE_RUN ? 8'h00 : tick ? sc_n : sc_q;
      pre_d = mode_p || mode_q != MODE_RUN || tick ? '0 : pre_q + 1'b1;
      bc_d = mode_p || inc_ok || mode_q == MODE_RUN || last ? '0 : bc_q + 1'b1;
      ph_d = mode_p || inc_ok || mode_q == MODE_RUN ? 1'b0 : ph_q ^ last;
      blank_d = !ph_d ? 4'b0000 : mode_d == MODE_SET_HR ? BLANK_HR : mode_d == MODE_SET_MIN ? BLANK_MIN : 4'b0000;
      colon_d = mode_d != MODE_RUN || pre_d < PW'(CLK_HZ / 2);
   end
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mode_q <= MODE_RUN;
         hr_q <= 8'h00;
         mn_q <= 8'h00;
         sc_q <= 8'h00;
         pre_q <= '0;
         bc_q <= '0;
         ph_q <= 1'b0;
         blank_q <= 4'b0000;
         colon_q <= 1'b1;
      end else begin
         mode_q <= mode_d;
         hr_q <= hr_d;
         mn_q <= mn_d;
         sc_q <= sc_d;
         pre_q <= pre_d;
         bc_q <= bc_d;
         ph_q <= ph_d;
         blank_q <= blank_d;
         colon_q <= colon_d;
      end
   end
   assign bus.in1 = hr_q[7:4];
   assign bus.in2 = hr_q[3:0];
   assign bus.in3 = mn_q[7:4];
   assign bus.in4 = mn_q[3:0];
   assign bus.blank = blank_q;
   assign bus.mode = mode_q;
   assign bus.colon = colon_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed and randomized checks of clock_mode_ctrl against a time-of-day model
module tb_clock_mode_ctrl;
   localparam int HZ = 8;
   localparam int DEB = 3;
   // raw edge after edge e takes effect at edge e+LAT: two sync edges, DEB samples, pulse consumed
   localparam int LAT = DEB + 3;
   logic clk = 1'b0;
   logic clr = 1'b0;
   clock_mode_ctrl_if ifc();
   clock_mode_ctrl #(.CLK_HZ(HZ), .DEB_CYCLES(DEB)) dut (.clk(clk), .clr(clr), .bus(ifc.slave));
   always #5 clk = ~clk;
   int errs = 0, checks = 0, ecount = 0;
   int secs, md, cyc, age;
   int pm[$], pi[$];
   logic [22:0] dv;
   assign dv = {ifc.in1, ifc.in2, ifc.in3, ifc.in4, ifc.blank, ifc.mode, ifc.colon};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, ecount);
      end
   endtask
   function automatic logic [22:0] ev();
      int h = secs / 3600;
      int m = (secs / 60) % 60;
      bit ph = (age / (HZ / 4)) % 2 == 1;
      logic [3:0] b = !ph ? 4'h0 : md == 1 ? 4'b1100 : md == 2 ? 4'b0011 : 4'h0;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), b, 2'(md), md != 0 || cyc < HZ / 2};
   endfunction
   task automatic model_reset();
      secs = 0;
      md = 0;
      cyc = 0;
      age = 0;
      pm.delete();
      pi.delete();
   endtask
   task automatic model_edge();
      bit mp, ip;
      mp = pm.size() > 0 && pm[0] == ecount;
      ip = pi.size() > 0 && pi[0] == ecount;
      if (mp) pm.delete(0);
      if (ip) pi.delete(0);
      if (md == 0) begin
         if (cyc == HZ - 1) begin
            cyc = 0;
            secs = (secs + 1) % 86400;
         end else cyc++;
      end else begin
         age++;
         if (ip && !mp) begin
            age = 0;
            if (md == 1) secs = ((secs / 3600 + 1) % 24) * 3600 + secs % 3600;
            else secs = (secs / 3600) * 3600 + (((secs / 60) % 60 + 1) % 60) * 60 + secs % 60;
         end
      end
      if (mp) begin
         md = (md + 1) % 3;
         secs -= secs % 60;
         cyc = 0;
         age = 0;
      end
   endtask
   task automatic step();
      @(posedge clk);
      ecount++;
      if (clr) model_reset();
      else model_edge();
      #1 chk("cycle", dv, ev());
   endtask
   task automatic hold(input bit m, input bit i, input int h, input int g, output int e);
      ifc.btn_mode = m;
      ifc.btn_inc = i;
      e = ecount + LAT;
      if (h >= DEB) begin
         if (m) pm.push_back(e);
         if (i) pi.push_back(e);
      end
      repeat (h) step();
      ifc.btn_mode = 1'b0;
      ifc.btn_inc = 1'b0;
      repeat (g) step();
   endtask
   task automatic press(input bit m, input bit i);
      int e;
      hold(m, i, DEB + 1 + int'($urandom_range(0, 6)), DEB + 2 + int'($urandom_range(0, 4)), e);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      int e, n, op;
      ifc.btn_mode = 1'b0;
      ifc.btn_inc = 1'b0;
      model_reset();
      #1 clr = 1'b1;
      repeat (2) step();
      chk("reset", dv, 23'h000001);
      clr = 1'b0;
      repeat (HZ * 60) step();
      chk("run_1min", dv[22:7], 16'h0001);
      chk("run_mode", ifc.mode, 0);
      chk("run_blank", ifc.blank, 0);
      press(1, 0);
      n = (23 - secs / 3600 + 24) % 24;
      repeat (n) press(0, 1);
      chk("hr_23", dv[22:15], 8'h23);
      press(1, 0);
      n = (59 - (secs / 60) % 60 + 60) % 60;
      repeat (n) press(0, 1);
      chk("min_59", dv[14:7], 8'h59);
      hold(1, 0, DEB + 1, 0, e);
      while (ecount < e) step();
      chk("run_entry", dv[22:7], 16'h2359);
      chk("run_entry_mode", ifc.mode, 0);
      repeat (HZ * 60 - 1) step();
      chk("pre_roll", dv[22:7], 16'h2359);
      step();
      chk("midnight", dv[22:7], 16'h0000);
      press(1, 0);
      repeat (25) press(0, 1);
      chk("hr_25", dv[22:15], 8'h01);
      chk("hr_mode", ifc.mode, 1);
      chk("hr_min", dv[14:7], 8'h00);
      press(1, 0);
      n = (59 - (secs / 60) % 60 + 60) % 60;
      repeat (n) press(0, 1);
      press(0, 1);
      chk("min_wrap", dv[14:7], 8'h00);
      chk("min_hr", dv[22:15], 8'h01);
      press(1, 0);
      press(1, 0);
      press(1, 1);
      chk("both_mode", ifc.mode, 2);
      chk("both_hr", dv[22:15], 8'h01);
      hold(0, 1, 2, DEB + 4, e);
      chk("glitch", dv[14:7], 8'h00);
      hold(0, 1, 100, DEB + 4, e);
      chk("held", dv[14:7], 8'h01);
      clr = 1'b1;
      model_reset();
      #1 chk("clr_async", dv, 23'h000001);
      repeat (2) step();
      clr = 1'b0;
      for (int k = 0; k < 80; k++) begin
         op = int'($urandom_range(0, 5));
         if (op == 0) repeat ($urandom_range(1, 30)) step();
         else if (op == 1) press(1, 0);
         else if (op <= 3) press(0, 1);
         else if (op == 4) hold(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(1, DEB - 1)), DEB + 2, e);
         else press(1, 1);
      end
      repeat (HZ * 4) step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Time-keeping and set-mode controller for the FPGA digital clock. Keeps 24-hour HH:MM:SS in BCD from a 1 Hz tick derived from the system clock, runs a two-button set-mode state machine and drives the four BCD digit inputs of the seven-segment driver. It also produces a per-digit blank mask that the top level uses to blink the field being edited. Sits between the board pushbuttons and the display driver.

## Interface
- CLK_HZ, 100_000_000, system clock cycles per second tick; must be ≥ 4
- DEB_CYCLES, 1_000_000, consecutive stable synchronized samples required to accept a button level change
- clk  input  1  system clock, all logic on rising edge
- clr  input  1  reset; one clock; reset is asynchronous and active-high
- btn_mode  input  1  raw pushbutton, active-high, asynchronous to clk
- btn_inc  input  1  raw pushbutton, active-high, asynchronous to clk
- in1  output  4  hour tens BCD, 0–2, leftmost digit
- in2  output  4  hour ones BCD, 0–9
- in3  output  4  minute tens BCD, 0–5
- in4  output  4  minute ones BCD, 0–9, rightmost digit
- blank  output  4  blank[3] pairs with in1 … blank[0] with in4; 1 = digit dark
- mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN
- colon  output  1  high for the first half of each second in RUN, constantly high in set states

## Operation
- Reset: all time digits 0, which gives 00:00:00. mode=RUN, blank=0000, colon=1. Prescaler, blink phase and debouncers cleared. Reset mid-edit abandons the edit.
- Buttons: 2-flop synchronizer, then the debouncer. The accepted level changes only after DEB_CYCLES equal samples. A press is a single-cycle pulse on the accepted 0→1 transition. Release produces no pulse. Holding a button gives exactly one pulse.
- FSM:
  - RUN → SET_HR on mode press.
  - SET_HR → SET_MIN on mode press.
  - SET_MIN → RUN on mode press.
- RUN:
  - Prescaler counts 0..CLK_HZ-1. A tick fires when it reaches CLK_HZ-1, then the prescaler wraps to 0.
  - Each tick advances seconds with BCD carry into minutes and minutes into hours. 23:59:59 → 00:00:00.
  - inc presses are ignored.
- SET_HR / SET_MIN:
  - Ticks do not advance time. Seconds are held at 00. The prescaler is held at 0.
  - An inc press adds 1 to the selected field only, with no carry: hours 23→00, minutes 59→00.
- Leaving SET_MIN for RUN: seconds=00 and prescaler=0, so the first tick comes exactly CLK_HZ cycles after the transition.
- Blink:
  - A phase bit toggles every CLK_HZ/4 cycles while in a set state.
  - The phase is forced to visible (0) on entering a set state and on every inc press.
  - phase=1 blanks the selected field's two digits: SET_HR → blank=1100, SET_MIN → blank=0011.
  - RUN → blank=0000.
- Simultaneous mode and inc pulses in the same cycle: the mode transition is taken and inc is ignored.

## Timing
- Button latency: raw edge → press pulse after 2 sync cycles + DEB_CYCLES cycles (±1).
- Press pulse at cycle N:
  - mode output and field value are updated at the register edge ending cycle N.
  - Outputs are valid in cycle N+1.
- Tick at cycle N: new digits are visible in cycle N+1.
- All outputs are registered. No combinational path from buttons to outputs.

## Structure
- Shared package clock_pkg holds:
  - mode encodings MODE_RUN, MODE_SET_HR, MODE_SET_MIN
  - BCD limit constants: HR_MAX 23, MIN_MAX 59, SEC_MAX 59
  - blank-mask constants BLANK_HR 4'b1100, BLANK_MIN 4'b0011
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, clr, raw, press). It holds the synchronizer, stability counter and rising-edge pulse, and is instantiated once per button.
- Time counters, prescaler, FSM and blink logic are inline in clock_mode_ctrl.

## Test plan
All scenarios use CLK_HZ=8, DEB_CYCLES=3.
- Reset, then 60×8 cycles in RUN -> in1..in4 = 0,0,0,1, mode=00, blank=0000.
- Preload 23:59:59 via set mode plus ticks, then one tick -> 0,0,0,0, seconds=0.
- Mode press, then 25 inc presses -> mode=01, hours 23→00→01, i.e. in1,in2 = 0,1; minutes unchanged.
- In SET_MIN at 59, one inc press -> minutes 00, hours unchanged. Then mode press -> mode=00, and the first minute rolls over exactly 60×8 cycles after the transition.
- Button glitch of 2 cycles -> no pulse. Button held 100 cycles -> exactly one increment.
- Mode and inc debounced on the same cycle in SET_HR -> mode=10 and hours unchanged. Assert clr mid-SET_MIN -> immediately 00:00, mode=00, blank=0000.
